// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_REG_READ = 1'b0,
    FIFO_FWFT     = 1'b1
  } fifo_mode_e;

  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = fifo_addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and optional first-word-fall-through output.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int AW      = fifo_addr_w(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam fifo_mode_e    MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG_READ;
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be >= 1");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             ovf_q, unf_q;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] head_data;

  assign wr_ok = wr & ~full_q;
  assign rd_ok = rd & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
    count_d  = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Wrap bits differ with equal addresses only when the writer is a lap ahead.
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= wr & full_q;
      unf_q    <= rd & empty_q;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (head_data)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out = head_data;
  end else begin : g_reg_read
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= head_data;
      end
    end
    assign data_out = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: one registered-read FIFO driven from a vector table, one FWFT FIFO for head visibility.
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance (a) and fall-through instance (b)
  logic       rst_a, wr_a, rd_a;
  logic [7:0] din_a, dout_a;
  logic       full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [4:0] cnt_a;

  logic       rst_b, wr_b, rd_b;
  logic [7:0] din_b, dout_b;
  logic       full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [4:0] cnt_b;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_a), .wr(wr_a), .data_in(din_a), .rd(rd_a), .data_out(dout_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(cnt_a), .overflow(ovf_a), .underflow(unf_a)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_b), .wr(wr_b), .data_in(din_b), .rd(rd_b), .data_out(dout_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(cnt_b), .overflow(ovf_b), .underflow(unf_b)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic       chk_d;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic r, input logic [7:0] d,
                              input int c, input logic o, input logic u,
                              input logic cd, input logic [7:0] q);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d;
    v.cnt   = 5'(c);
    v.full  = (c == 16);
    v.empty = (c == 0);
    v.af    = (c >= 14);
    v.ae    = (c <= 2);
    v.ovf = o; v.unf = u; v.chk_d = cd; v.dout = q;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    wr_a = 0; rd_a = 0; din_a = 0;
    wr_b = 0; rd_b = 0; din_b = 0;

    // Fill 0x01..0x10, overflow, drain, underflow
    for (int i = 1; i <= 16; i++) add(1, 0, 8'(i), i, 0, 0, 0, 0);
    add(1, 0, 8'hEE, 16, 1, 0, 0, 0);
    add(0, 0, 8'h00, 16, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(0, 1, 0, 16 - i, 0, 0, 1, 8'(i));
    add(0, 1, 8'h00, 0, 0, 1, 1, 8'h10);
    add(0, 0, 8'h00, 0, 0, 0, 1, 8'h10);
    // Underflow case with simultaneous write: write accepted, no bypass
    add(1, 1, 8'h77, 1, 0, 1, 1, 8'h10);
    add(0, 1, 8'h00, 0, 0, 0, 1, 8'h77);
    // Simultaneous traffic at count 8, pointers wrap
    for (int i = 0; i < 8; i++) add(1, 0, 8'h20 + 8'(i), i + 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      add(1, 1, 8'h30 + 8'(k), 8, 0, 0, 1, (k < 8) ? 8'h20 + 8'(k) : 8'h30 + 8'(k - 8));
    for (int k = 0; k < 8; k++) add(0, 1, 0, 7 - k, 0, 0, 1, 8'h30 + 8'(12 + k));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", cnt_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_ae", ae_a, 1);
    check("rst_full", full_a, 0);
    check("rst_af", af_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_unf", unf_a, 0);
    check("rst_dout", dout_a, 0);
    check("rst_b_empty", empty_b, 1);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      wr_a = vecs[i].wr; rd_a = vecs[i].rd; din_a = vecs[i].din;
      @(posedge clk); #1;
      $display("vec %0d wr=%0b rd=%0b din=%02h -> cnt=%0d dout=%02h", i, wr_a, rd_a, din_a, cnt_a, dout_a);
      check($sformatf("v%0d_count", i), cnt_a, vecs[i].cnt);
      check($sformatf("v%0d_full", i), full_a, vecs[i].full);
      check($sformatf("v%0d_empty", i), empty_a, vecs[i].empty);
      check($sformatf("v%0d_af", i), af_a, vecs[i].af);
      check($sformatf("v%0d_ae", i), ae_a, vecs[i].ae);
      check($sformatf("v%0d_ovf", i), ovf_a, vecs[i].ovf);
      check($sformatf("v%0d_unf", i), unf_a, vecs[i].unf);
      if (vecs[i].chk_d) check($sformatf("v%0d_dout", i), dout_a, vecs[i].dout);
    end
    wr_a = 0; rd_a = 0;

    // FWFT: head visible after the write without a read, pop empties
    wr_b = 1; din_b = 8'hA5;
    @(posedge clk); #1;
    wr_b = 0;
    $display("fwft write A5 -> dout=%02h cnt=%0d", dout_b, cnt_b);
    check("fwft_dout", dout_b, 8'hA5);
    check("fwft_empty0", empty_b, 0);
    check("fwft_count1", cnt_b, 1);
    rd_b = 1;
    @(posedge clk); #1;
    rd_b = 0;
    $display("fwft pop -> empty=%0b cnt=%0d", empty_b, cnt_b);
    check("fwft_empty1", empty_b, 1);
    check("fwft_count0", cnt_b, 0);
    check("fwft_unf", unf_b, 0);

    // Asynchronous reset at count 5, asserted between edges
    for (int i = 0; i < 5; i++) begin
      wr_a = 1; din_a = 8'h50 + 8'(i);
      @(posedge clk); #1;
    end
    wr_a = 0;
    $display("pre-reset cnt=%0d", cnt_a);
    check("pre_rst_count", cnt_a, 5);
    @(negedge clk); #2;
    rst_a = 1'b0;
    #1;
    $display("async reset -> cnt=%0d empty=%0b dout=%02h", cnt_a, empty_a, dout_a);
    check("arst_count", cnt_a, 0);
    check("arst_empty", empty_a, 1);
    check("arst_ae", ae_a, 1);
    check("arst_af", af_a, 0);
    check("arst_dout", dout_a, 0);
    #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    wr_a = 1; din_a = 8'h3C;
    @(posedge clk); #1;
    wr_a = 0;
    check("post_rst_count", cnt_a, 1);
    rd_a = 1;
    @(posedge clk); #1;
    rd_a = 0;
    $display("post-reset read -> dout=%02h empty=%0b", dout_a, empty_a);
    check("post_rst_dout", dout_a, 8'h3C);
    check("post_rst_empty", empty_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
